// File: rtl/alu_seq.sv
// alu_seq: sequential ALU; single-cycle ADD/SUB/logic/SHIFT, WIDTH-cycle MUL/DIV.
// Ports: clk, reset_n (sync, active-low), start/op/mode/a/b/cin in; busy, done,
// result, result_hi, zout, cout, dbz out. Macro ALU_SEQ_DIVIDE_EN enables DIV.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zout,
  output logic             cout,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHF = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             accept;

  // Working registers: acc is MUL high half / DIV partial remainder,
  // wq is MUL multiplier / DIV dividend-then-quotient, wd the other operand.
  logic [WIDTH-1:0] acc, wq, wd;
  logic [WIDTH-1:0] acc_nx, wq_nx;

  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_c, s_d, s_multi;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   madd;
  logic [SHW-1:0]   sh;

`ifdef ALU_SEQ_DIVIDE_EN
  logic             is_div;
  logic [WIDTH:0]   shl, diff;
`endif

  assign busy   = (state == EXEC);
  assign accept = start & ~busy;
  assign sh     = b[SHW-1:0];

  always_comb begin
    s_res   = '0;
    s_hi    = '0;
    s_c     = 1'b0;
    s_d     = 1'b0;
    s_multi = 1'b0;
    sum     = '0;
    wide    = '0;
    unique case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, mode[0] & cin};
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
      end
      OP_SUB: begin
        // a + ~b + 1 - borrow; carry out set means no borrow
        sum   = {1'b0, a} + {1'b0, ~b}
              + {{WIDTH{1'b0}}, mode[0] ? cin : 1'b1};
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_SHF: begin
        // extra guard bit catches the last bit shifted out
        if (mode[0]) begin
          if (mode[1])
            wide = $signed({a, 1'b0}) >>> sh;
          else
            wide = {a, 1'b0} >> sh;
          s_res = wide[WIDTH:1];
          s_c   = wide[0];
        end else begin
          wide  = {1'b0, a} << sh;
          s_res = wide[WIDTH-1:0];
          s_c   = wide[WIDTH];
        end
      end
      OP_MUL: s_multi = 1'b1;
      OP_DIV: begin
`ifdef ALU_SEQ_DIVIDE_EN
        if (b == '0) begin
          s_res = '1;
          s_hi  = a;
          s_d   = 1'b1;
        end else begin
          s_multi = 1'b1;
        end
`endif
      end
    endcase
  end

  always_comb begin
    madd   = {1'b0, acc} + (wq[0] ? {1'b0, wd} : '0);
    acc_nx = madd[WIDTH:1];
    wq_nx  = {madd[0], wq[WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDE_EN
    shl  = {acc, wq[WIDTH-1]};
    diff = shl - {1'b0, wd};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        wq_nx  = {wq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shl[WIDTH-1:0];
        wq_nx  = {wq[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && s_multi) state_nx = EXEC;
      EXEC: if (cnt == CW'(1))     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zout      <= 1'b0;
      cout      <= 1'b0;
      dbz       <= 1'b0;
      acc       <= '0;
      wq        <= '0;
      wd        <= '0;
`ifdef ALU_SEQ_DIVIDE_EN
      is_div    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state == EXEC) begin
        acc <= acc_nx;
        wq  <= wq_nx;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done      <= 1'b1;
          result    <= wq_nx;
          result_hi <= acc_nx;
          zout      <= (wq_nx == '0);
          dbz       <= 1'b0;
`ifdef ALU_SEQ_DIVIDE_EN
          cout      <= ~is_div & (acc_nx != '0);
`else
          cout      <= (acc_nx != '0);
`endif
        end
      end else if (accept) begin
        if (s_multi) begin
          cnt <= CW'(WIDTH);
          acc <= '0;
          wq  <= a;
          wd  <= b;
`ifdef ALU_SEQ_DIVIDE_EN
          is_div <= (op == OP_DIV);
`endif
        end else begin
          done      <= 1'b1;
          result    <= s_res;
          result_hi <= s_hi;
          zout      <= (s_res == '0);
          cout      <= s_c;
          dbz       <= s_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random + directed checks of alu_seq (WIDTH=8 and WIDTH=16)
// against a behavioural model; define ALU_SEQ_DIVIDE_EN to cover DIV.
module tb_alu_seq;

`ifdef ALU_SEQ_DIVIDE_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, start16, cin;
  logic [2:0]  op;
  logic [1:0]  mode;
  logic [7:0]  a, b;
  logic [15:0] a16, b16;

  logic        busy8, done8, z8, c8, d8;
  logic [7:0]  res8, hi8;
  logic        busy16, done16, z16, c16, d16;
  logic [15:0] res16, hi16;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .op(op), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy8), .done(done8),
    .result(res8), .result_hi(hi8),
    .zout(z8), .cout(c8), .dbz(d8)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .start(start16),
    .op(op), .mode(mode), .a(a16), .b(b16), .cin(cin),
    .busy(busy16), .done(done16),
    .result(res16), .result_hi(hi16),
    .zout(z16), .cout(c16), .dbz(d16)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] h;
    logic       z;
    logic       c;
    logic       d;
  } exp_t;

  function automatic exp_t ref_op(input logic [2:0] o,
                                  input logic [1:0] m,
                                  input logic [7:0] x,
                                  input logic [7:0] y,
                                  input logic ci);
    exp_t e;
    int xi, yi, v, sa, s;
    e  = '0;
    xi = int'(x);
    yi = int'(y);
    s  = yi % 8;
    v  = 0;
    case (o)
      3'd0: begin
        v   = xi + yi + ((m[0] && ci) ? 1 : 0);
        e.r = v[7:0];
        e.c = (v > 255);
      end
      3'd1: begin
        v   = xi - yi - ((m[0] && !ci) ? 1 : 0);
        e.r = v[7:0];
        e.c = (v >= 0);
      end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: begin
        if (!m[0]) begin
          v   = xi << s;
          e.r = v[7:0];
          e.c = v[8];
        end else begin
          e.c = (s == 0) ? 1'b0 : 1'((xi >> (s - 1)) & 1);
          if (m[1]) begin
            sa = (xi >= 128) ? xi - 256 : xi;
            v  = sa >>> s;
          end else begin
            v = xi >> s;
          end
          e.r = v[7:0];
        end
      end
      3'd6: begin
        v   = xi * yi;
        e.r = v[7:0];
        e.h = v[15:8];
        e.c = (e.h != 0);
      end
      default: begin
        if (DIVEN) begin
          if (yi == 0) begin
            e.r = 8'hFF;
            e.h = x;
            e.d = 1'b1;
          end else begin
            v   = xi / yi;
            e.r = v[7:0];
            v   = xi % yi;
            e.h = v[7:0];
          end
        end
      end
    endcase
    e.z = (e.r == 8'd0);
    return e;
  endfunction

  task automatic run8(input logic [2:0] o, input logic [1:0] m,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic ci, input bit poke);
    exp_t e;
    int lat;
    logic [7:0] prev;
    e    = ref_op(o, m, x, y, ci);
    lat  = (o == 3'd6 || (o == 3'd7 && DIVEN && y != 0)) ? 9 : 1;
    prev = res8;
    @(negedge clk);
    op = o; mode = m; a = x; b = y; cin = ci; start = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (i < lat) begin
        check("busy", busy8, 1);
        check("early_done", done8, 0);
        check("hold", res8, prev);
      end else begin
        check("busy_end", busy8, 0);
        check("done", done8, 1);
        check("result", res8, e.r);
        check("result_hi", hi8, e.h);
        check("zout", z8, e.z);
        check("dbz", d8, e.d);
        if (o != 3'd7) check("cout", c8, e.c);
      end
      if (poke && i == 4) begin
        start = 1'b1; op = 3'd0;
        a = 8'($urandom); b = 8'($urandom);
      end
    end
    @(negedge clk);
    check("done_pulse", done8, 0);
    check("result_kept", res8, e.r);
  endtask

  task automatic b2b16(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] p, input logic [15:0] q);
    longint prod, sum;
    prod = longint'(x) * longint'(y);
    sum  = longint'(p) + longint'(q);
    @(negedge clk);
    op = 3'd6; mode = 2'd0; cin = 1'b0;
    a16 = x; b16 = y; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i < 17) begin
        check("w16_busy", busy16, 1);
        check("w16_early", done16, 0);
      end
    end
    check("w16_mul_done", done16, 1);
    check("w16_mul_lo", res16, 32'(prod[15:0]));
    check("w16_mul_hi", hi16, 32'(prod[31:16]));
    check("w16_mul_c", c16, (prod[31:16] != 0));
    op = 3'd0; a16 = p; b16 = q; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    check("w16_add_done", done16, 1);
    check("w16_add_busy", busy16, 0);
    check("w16_add_r", res16, 32'(sum[15:0]));
    check("w16_add_c", c16, 32'(sum[16]));
    check("w16_add_hi", hi16, 0);
  endtask

  task automatic reset_mid_mul();
    @(negedge clk);
    op = 3'd6; mode = 2'd0; a = 8'hA5; b = 8'h3C; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1; op = 3'd0;
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_res", res8, 0);
    check("rst_hi", hi8, 0);
    check("rst_flags", {z8, c8, d8}, 0);
    reset_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_no_done", done8, 0);
    end
    run8(3'd0, 2'd0, 8'h12, 8'h34, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; start16 = 1'b0;
    op = '0; mode = '0; cin = 1'b0;
    a = '0; b = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_res", res8, 0);
    check("reset_hi", hi8, 0);
    check("reset_flags", {z8, c8, d8}, 0);
    check("reset_w16", {busy16, done16, res16}, 0);
    reset_n = 1'b1;

    run8(3'd0, 2'b01, 8'hF0, 8'h20, 1'b1, 1'b0);
    run8(3'd6, 2'b00, 8'hFF, 8'hFF, 1'b0, 1'b1);
    run8(3'd7, 2'b00, 8'd200, 8'd7, 1'b0, 1'b0);
    run8(3'd7, 2'b00, 8'h55, 8'h00, 1'b0, 1'b0);
    run8(3'd5, 2'b11, 8'h81, 8'h01, 1'b0, 1'b0);
    run8(3'd1, 2'b00, 8'h05, 8'h05, 1'b0, 1'b0);
    run8(3'd5, 2'b00, 8'h81, 8'h00, 1'b0, 1'b0);
    run8(3'd1, 2'b01, 8'h05, 8'h05, 1'b0, 1'b0);

    reset_mid_mul();

    b2b16(16'hFFFF, 16'hFFFF, 16'h8000, 16'h8001);
    for (int i = 0; i < 3; i++)
      b2b16(16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));

    for (int i = 0; i < 200; i++) begin
      logic [2:0] ro;
      logic [7:0] rb;
      ro = 3'($urandom);
      rb = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      run8(ro, 2'($urandom), 8'($urandom), rb,
           1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, datapath width in bits (legal values 4, 8, 16, 32).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from b.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port op, input, 3, operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHIFT, 110 MUL, 111 DIV.
REQ-007 The block SHALL have port mode, input, 2, where bit0 means take carry (ADD/SUB) or right shift (SHIFT), and bit1 means arithmetic shift (SHIFT only).
REQ-008 The block SHALL have ports a and b, input, WIDTH each, operands captured on start acceptance.
REQ-009 The block SHALL have port cin, input, 1, carry/borrow in, captured on start acceptance.
REQ-010 The block SHALL have port busy, output, 1, high while a multi-cycle operation is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-012 The block SHALL have ports result and result_hi, output, WIDTH each, carrying the primary result and the MUL high half or DIV remainder.
REQ-013 The block SHALL have ports zout, cout and dbz, output, 1 each: zero flag, carry flag, divide-by-zero flag.

Function
REQ-014 The block SHALL implement FSM states IDLE and EXEC, where EXEC holds a down-counter cnt of WIDTH initial value.
REQ-015 The block SHALL accept start only when busy=0, including the cycle in which done=1, so back-to-back issue has no gap; start while busy=1 SHALL be ignored with no side effect.
REQ-016 For an accept at edge k of ADD/SUB/AND/OR/XOR/SHIFT, the block SHALL drive done=1 in cycle k+1, keep busy=0 throughout, and present registered results in the same cycle.
REQ-017 For an accept at edge k of MUL or DIV, the block SHALL drive busy=1 for cycles k+1..k+WIDTH and done=1 with busy=0 in cycle k+WIDTH+1.
REQ-018 ADD SHALL compute a+b+(mode[0]?cin:0), and SUB SHALL compute a-b-(mode[0]?~cin:0); both in WIDTH+1 bits with cout = bit WIDTH, where for SUB cout=1 means no borrow.
REQ-019 SHIFT SHALL shift a by b[SHW-1:0]: left when mode[0]=0, right when mode[0]=1, sign-filling when mode[1]=1 and mode[0]=1; cout SHALL be the last bit shifted out, or 0 for a shift of 0.
REQ-020 MUL SHALL be unsigned shift-add, one partial product per cycle, with {result_hi,result}=a*b and cout=(result_hi!=0).
REQ-021 DIV SHALL be unsigned restoring division, one quotient bit per cycle, with result=a/b and result_hi=a%b.
REQ-022 DIV with b=0 SHALL complete as a single-cycle op (done in k+1, busy never high) with result all ones, result_hi=a and dbz=1.
REQ-023 dbz SHALL be 0 for every other completion.
REQ-024 For non-MUL/DIV ops result_hi SHALL be 0, and for AND/OR/XOR cout SHALL be 0.
REQ-025 The block SHALL compute zout=(result==0) on the low half only.
REQ-026 result, result_hi, zout, cout and dbz SHALL hold their values from done until the next completion and SHALL NOT change during EXEC.

Reset
REQ-027 When reset_n=0 at a clock edge, the FSM SHALL go to IDLE, cnt=0, busy=0, done=0, result=0, result_hi=0, zout=0, cout=0 and dbz=0.
REQ-028 A reset during EXEC SHALL abort the operation with no done pulse, and start SHALL be ignored in any cycle where reset_n=0.

Configuration
REQ-029 With macro ALU_SEQ_DIVIDE_EN defined, DIV SHALL be implemented as in REQ-021 and REQ-022.
REQ-030 Without ALU_SEQ_DIVIDE_EN, op 111 SHALL complete as a single-cycle op with result=0, result_hi=0, zout=1, cout=0 and dbz=0, and no divider logic SHALL be synthesised.

Verification
REQ-031 With WIDTH=8, ADD a=0xF0, b=0x20, mode=01, cin=1 SHALL give done at k+1, result=0x11, cout=1 and zout=0.
REQ-032 With WIDTH=8, MUL a=0xFF, b=0xFF SHALL give busy in k+1..k+8, done at k+9, result=0x01, result_hi=0xFE and cout=1; a start pulse at k+4 SHALL be ignored.
REQ-033 With WIDTH=8 and ALU_SEQ_DIVIDE_EN, DIV a=200, b=7 SHALL give done at k+9 with result=28 and result_hi=4; DIV a=0x55, b=0 SHALL give done at k+1 with result=0xFF, result_hi=0x55 and dbz=1.
REQ-034 With WIDTH=8, SHIFT a=0x81, b=1, mode=11 SHALL give result=0xC0 and cout=1; SUB a=0x05, b=0x05, mode=00 SHALL give result=0, zout=1 and cout=1.
REQ-035 With WIDTH=8, reset_n=0 asserted at k+3 of a MUL SHALL produce no done pulse and zero all outputs; a new ADD issued after reset release SHALL complete normally.
REQ-036 With WIDTH=16, a MUL followed by an ADD issued in the MUL's done cycle SHALL give done at k+17 and again at k+18 with correct results.
